// File: rtl/cc_fill_deserializer.sv
// Cache-line fill deserializer: gathers a wrapping 8 x 64-bit MEM read burst into one
// 512-bit line. Each word lands at its position relative to the queued critical-word offset.
module cc_fill_deserializer #(
  parameter int OFS_DEPTH = 4,
  parameter int BEATS     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid_i,
  input  logic [5:0]   req_offset_i,
  output logic         req_ready_o,
  input  logic [63:0]  mem_rdata_i,
  input  logic         mem_rlast_i,
  input  logic         mem_rvalid_i,
  output logic         mem_rready_o,
  output logic         line_valid_o,
  output logic [511:0] line_data_o,
  output logic [5:0]   line_offset_o,
  input  logic         line_ready_i,
  output logic         err_o
);

  localparam int PW = $clog2(OFS_DEPTH);
  localparam int CW = PW + 1;
  localparam int KW = $clog2(BEATS);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_OUT} state_t;

  state_t          state_q, state_d;
  logic [5:0]      fifo_mem [OFS_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [5:0]      ofs_q;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   wr_idx;
  logic [63:0]     line_q [BEATS];
  logic            err_q;
  logic            push, pop, hs, last_beat;

  assign req_ready_o = (count_q != CW'(OFS_DEPTH));
  assign push        = req_valid_i && req_ready_o;
  assign pop         = (state_q == S_IDLE) && (count_q != '0);
  assign hs          = mem_rvalid_i && mem_rready_o;
  assign last_beat   = hs && (mem_rlast_i || (k_q == KW'(BEATS - 1)));
  // Start word plus beat count, wrapping within the line.
  assign wr_idx      = ofs_q[5:3] + k_q;

  // Offset FIFO
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= req_offset_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (pop)          state_d = S_COLLECT;
      S_COLLECT: if (last_beat)    state_d = S_OUT;
      S_OUT:     if (line_ready_i) state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mem_rready_o = 1'b0;
    line_valid_o = 1'b0;
    case (state_q)
      S_COLLECT: mem_rready_o = 1'b1;
      S_OUT:     line_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ofs_q <= '0;
      k_q   <= '0;
      err_q <= 1'b0;
    end else begin
      if (pop) begin
        ofs_q <= fifo_mem[rd_ptr_q];
        k_q   <= '0;
      end else if (hs) begin
        k_q <= k_q + 1'b1;
      end
      // rlast must coincide exactly with the final beat of the line.
      if (last_beat && (mem_rlast_i != (k_q == KW'(BEATS - 1)))) begin
        err_q <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_word
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          line_q[gi] <= '0;
        end else if (pop) begin
          line_q[gi] <= '0;
        end else if (hs && (wr_idx == KW'(gi))) begin
          line_q[gi] <= mem_rdata_i;
        end
      end
      assign line_data_o[64*gi +: 64] = line_q[gi];
    end
  endgenerate

  assign line_offset_o = ofs_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_cc_fill_deserializer.sv
// Randomized self-checking bench for cc_fill_deserializer; expected lines come from
// a word-placement model built from the offset and the list of beats sent.
module tb_cc_fill_deserializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic [5:0]   req_offset;
  logic         req_ready;
  logic [63:0]  mem_rdata;
  logic         mem_rlast;
  logic         mem_rvalid;
  logic         mem_rready;
  logic         line_valid;
  logic [511:0] line_data;
  logic [5:0]   line_offset;
  logic         line_ready;
  logic         err;

  int           checks = 0;
  int           errors = 0;
  bit           exp_err = 1'b0;
  logic [63:0]  beat_d [8];

  always #5 clk = ~clk;

  cc_fill_deserializer #(.OFS_DEPTH(4), .BEATS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_offset_i(req_offset), .req_ready_o(req_ready),
    .mem_rdata_i(mem_rdata), .mem_rlast_i(mem_rlast), .mem_rvalid_i(mem_rvalid),
    .mem_rready_o(mem_rready),
    .line_valid_o(line_valid), .line_data_o(line_data), .line_offset_o(line_offset),
    .line_ready_i(line_ready), .err_o(err)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Beat i goes to word (offset/8 + i) mod 8; words never sent read as zero.
  function automatic logic [511:0] model_line(input logic [5:0] o, input int n);
    logic [511:0] l = '0;
    for (int i = 0; i < n; i++) begin
      int w = (int'(o) / 8 + i) % 8;
      l[w*64 +: 64] = beat_d[i];
    end
    return l;
  endfunction

  task automatic rand_beats();
    for (int i = 0; i < 8; i++) beat_d[i] = {$urandom, $urandom};
  endtask

  task automatic push(input logic [5:0] o);
    req_valid  = 1'b1;
    req_offset = o;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic send_beats(input int n, input bit rl, input bit gaps, output bit ok);
    int t;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          mem_rvalid = 1'b0;
          step();
        end
      end
      mem_rvalid = 1'b1;
      mem_rdata  = beat_d[i];
      mem_rlast  = rl && (i == n - 1);
      t = 0;
      while (!mem_rready && t < 50) begin
        step();
        t++;
      end
      if (!mem_rready) begin
        ok = 1'b0;
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        return;
      end
      step();
    end
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
  endtask

  task automatic wait_line(output bit ok);
    int t = 0;
    while (!line_valid && t < 40) begin
      step();
      t++;
    end
    ok = line_valid;
  endtask

  task automatic accept();
    line_ready = 1'b1;
    step();
    line_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (mem_rready !== 1'b0) begin errors++; $display("FAIL reset_mem_rready: got %b want 0", mem_rready); end
    checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL reset_line_valid: got %b want 0", line_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (line_data !== '0) begin errors++; $display("FAIL reset_line_data: got %h want 0", line_data); end
    checks++; if (line_offset !== 6'h0) begin errors++; $display("FAIL reset_line_offset: got %h want 0", line_offset); end
    rst_n = 1'b1;
    step();
    $display("reset: checked idle outputs");
  endtask

  task automatic test_aligned();
    bit ok;
    for (int i = 0; i < 8; i++) beat_d[i] = 64'h1000 + 64'(i);
    push(6'h00);
    send_beats(8, 1'b1, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL aligned_handshake: got timeout want 8 beats"); end
    // Line must be valid the cycle right after the last-beat handshake.
    checks++; if (line_valid !== 1'b1) begin errors++; $display("FAIL aligned_latency: got valid=%b want 1", line_valid); end
    checks++; if (line_data !== model_line(6'h00, 8)) begin errors++; $display("FAIL aligned_data: got %h want %h", line_data, model_line(6'h00, 8)); end
    checks++; if (line_offset !== 6'h00) begin errors++; $display("FAIL aligned_offset: got %h want 00", line_offset); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL aligned_err: got %b want 0", err); end
    accept();
    checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL aligned_release: got valid=%b want 0", line_valid); end
    $display("aligned: line ofs=%h", 6'h00);
  endtask

  task automatic test_wrapped();
    bit ok;
    logic [511:0] exp_line;
    rand_beats();
    exp_line = '0;
    for (int i = 0; i < 8; i++) exp_line[((5 + i) % 8)*64 +: 64] = beat_d[i];
    push(6'h28);
    send_beats(8, 1'b1, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrapped_handshake: got timeout want 8 beats"); end
    wait_line(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrapped_valid: got timeout want line"); end
    checks++; if (line_data !== exp_line) begin errors++; $display("FAIL wrapped_data: got %h want %h", line_data, exp_line); end
    checks++; if (line_offset !== 6'h28) begin errors++; $display("FAIL wrapped_offset: got %h want 28", line_offset); end
    accept();
    $display("wrapped: line ofs=%h", 6'h28);
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [511:0] held;
    rand_beats();
    push(6'h10);
    push(6'h3a);
    send_beats(8, 1'b1, 1'b0, ok);
    wait_line(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_valid: got timeout want line"); end
    checks++; if (line_data !== model_line(6'h10, 8)) begin errors++; $display("FAIL bp_data: got %h want %h", line_data, model_line(6'h10, 8)); end
    held = model_line(6'h10, 8);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hdead_beef_0bad_f00d;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (line_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c%0d: got %b want 1", c, line_valid); end
      checks++; if (line_data !== held) begin errors++; $display("FAIL bp_hold_data c%0d: got %h want %h", c, line_data, held); end
      checks++; if (mem_rready !== 1'b0) begin errors++; $display("FAIL bp_rready c%0d: got %b want 0", c, mem_rready); end
    end
    mem_rvalid = 1'b0;
    accept();
    checks++; if (mem_rready !== 1'b0 || line_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_cycle: got rready=%b valid=%b want 0 0", mem_rready, line_valid); end
    step();
    checks++; if (mem_rready !== 1'b1) begin errors++; $display("FAIL bp_second_start: got rready=%b want 1", mem_rready); end
    rand_beats();
    send_beats(8, 1'b1, 1'b0, ok);
    wait_line(ok);
    checks++; if (line_data !== model_line(6'h3a, 8) || line_offset !== 6'h3a) begin errors++; $display("FAIL bp_second_line: got ofs=%h data=%h want ofs=3a data=%h", line_offset, line_data, model_line(6'h3a, 8)); end
    accept();
    $display("backpressure: lines ofs=10 and ofs=3a");
  endtask

  task automatic test_fifo_full();
    bit ok;
    logic [5:0] q [$];
    logic [5:0] o;
    logic [5:0] exp_o;
    o = 6'($urandom);
    q.push_back(o);
    push(o);
    repeat (2) step();
    // One offset is now held by the collecting burst; four more fill the queue.
    for (int i = 0; i < 4; i++) begin
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_ready_before_%0d: got %b want 1", i, req_ready); end
      o = 6'($urandom);
      q.push_back(o);
      push(o);
    end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready_after: got %b want 0", req_ready); end
    push(6'h3f);
    while (q.size() > 0) begin
      exp_o = q.pop_front();
      rand_beats();
      send_beats(8, 1'b1, 1'b1, ok);
      wait_line(ok);
      checks++; if (!ok) begin errors++; $display("FAIL full_drain_valid: got timeout want line ofs=%h", exp_o); end
      checks++; if (line_offset !== exp_o || line_data !== model_line(exp_o, 8)) begin errors++; $display("FAIL full_drain_line: got ofs=%h data=%h want ofs=%h data=%h", line_offset, line_data, exp_o, model_line(exp_o, 8)); end
      $display("fifo_full: drained line ofs=%h", line_offset);
      accept();
    end
    repeat (3) step();
    checks++; if (mem_rready !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL full_extra_burst: got rready=%b req_ready=%b want 0 1", mem_rready, req_ready); end
  endtask

  task automatic test_early_rlast();
    bit ok;
    rand_beats();
    push(6'h00);
    send_beats(4, 1'b1, 1'b0, ok);
    exp_err = 1'b1;
    checks++; if (line_valid !== 1'b1) begin errors++; $display("FAIL early_valid: got %b want 1", line_valid); end
    checks++; if (line_data !== model_line(6'h00, 4)) begin errors++; $display("FAIL early_data: got %h want %h", line_data, model_line(6'h00, 4)); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL early_err: got %b want 1", err); end
    accept();
    rand_beats();
    push(6'h18);
    send_beats(8, 1'b1, 1'b0, ok);
    checks++; if (line_data !== model_line(6'h18, 8)) begin errors++; $display("FAIL early_next_data: got %h want %h", line_data, model_line(6'h18, 8)); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL early_err_sticky: got %b want 1", err); end
    accept();
    $display("early_rlast: short line then good line, err=%b", err);
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    rand_beats();
    push(6'h20);
    send_beats(5, 1'b0, 1'b0, ok);
    mem_rvalid = 1'b1;
    mem_rdata  = beat_d[5];
    rst_n = 1'b0;
    step();
    exp_err = 1'b0;
    checks++; if (mem_rready !== 1'b0 || line_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_outputs: got rready=%b valid=%b req_ready=%b want 0 0 1", mem_rready, line_valid, req_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b want 0", err); end
    rst_n = 1'b1;
    repeat (3) step();
    checks++; if (mem_rready !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got rready=%b want 0", mem_rready); end
    mem_rvalid = 1'b0;
    rand_beats();
    push(6'h38);
    send_beats(8, 1'b1, 1'b0, ok);
    checks++; if (line_data !== model_line(6'h38, 8) || line_offset !== 6'h38) begin errors++; $display("FAIL rst_mid_fresh: got ofs=%h data=%h want ofs=38 data=%h", line_offset, line_data, model_line(6'h38, 8)); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_mid_fresh_err: got %b want 0", err); end
    accept();
    $display("reset_mid_burst: fresh line ofs=38");
  endtask

  task automatic test_random();
    bit ok;
    logic [5:0] o;
    logic [511:0] held;
    int mode, n;
    bit rl;
    for (int it = 0; it < 20; it++) begin
      o = 6'($urandom);
      mode = $urandom_range(0, 5);
      if (mode == 0)      begin n = $urandom_range(1, 7); rl = 1'b1; end
      else if (mode == 1) begin n = 8; rl = 1'b0; end
      else                begin n = 8; rl = 1'b1; end
      if (mode < 2) exp_err = 1'b1;
      rand_beats();
      push(o);
      send_beats(n, rl, 1'b1, ok);
      wait_line(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_valid it%0d: got timeout want line", it); end
      held = model_line(o, n);
      repeat ($urandom_range(0, 3)) begin
        step();
        checks++; if (line_valid !== 1'b1 || line_data !== held) begin errors++; $display("FAIL rand_hold it%0d: got valid=%b data=%h want 1 %h", it, line_valid, line_data, held); end
      end
      checks++; if (line_data !== held || line_offset !== o) begin errors++; $display("FAIL rand_line it%0d: got ofs=%h data=%h want ofs=%h data=%h", it, line_offset, line_data, o, held); end
      checks++; if (err !== exp_err) begin errors++; $display("FAIL rand_err it%0d: got %b want %b", it, err, exp_err); end
      $display("random it%0d: ofs=%h beats=%0d rlast=%b err=%b", it, o, n, rl, err);
      accept();
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_offset = '0;
    mem_rdata  = '0;
    mem_rlast  = 1'b0;
    mem_rvalid = 1'b0;
    line_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_aligned();
    test_wrapped();
    test_backpressure();
    test_fifo_full();
    test_early_rlast();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
